attractor_detect: RTL and testbench

- Tracks the state trajectory x[0], x[1], … of a W-gene Boolean network stepped by the network-update logic.
- Detects entry into an attractor of any period 1..DEPTH. A period-1 fixed point and a period-2 oscillation are both covered.
- Reports the period, the state at detection and the step count. Flags a timeout if no attractor is found within MAX_STEPS.
- Sits downstream of the gene-update block and feeds the result logger. One trajectory is tracked per start.

---
 rtl/attractor_detect.sv | 131 +++++++++++++
 tb/tb_attractor_detect.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/attractor_detect.sv
// ============================================================================
// Module   : attractor_detect
// Function : Watches a Boolean-network state trajectory and reports the first
//            attractor period (1..DEPTH), or a timeout after MAX_STEPS samples.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module attractor_detect #(
  parameter int W         = 8,
  parameter int DEPTH     = 8,
  parameter int STEP_W    = 8,
  parameter int MAX_STEPS = 255,
  parameter int PER_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              valid,
  input  logic [W-1:0]      x,
  output logic              found,
  output logic [PER_W-1:0]  period,
  output logic [W-1:0]      cycle_state,
  output logic [STEP_W-1:0] steps,
  output logic              timeout,
  output logic              busy
);

  localparam logic [STEP_W-1:0] c_max_steps = STEP_W'(MAX_STEPS);
  localparam logic [DEPTH-1:0]  c_hv_first  = DEPTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_TOUT = 2'd3
  } state_t;

  state_t              r_state;
  logic [W-1:0]        r_hist [DEPTH];
  logic [DEPTH-1:0]    r_hv;
  logic                r_found;
  logic [PER_W-1:0]    r_period;
  logic [W-1:0]        r_cycle_state;
  logic [STEP_W-1:0]   r_steps;
  logic                r_timeout;
  logic                r_busy;

  logic [DEPTH-1:0]    w_match;
  logic                w_hit;
  logic [PER_W-1:0]    w_per;
  logic [STEP_W-1:0]   w_steps_nxt;

  // w_match[k-1] flags a repeat of the state seen k samples ago
  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_match
      assign w_match[g] = r_hv[g] && (r_hist[g] == x);
    end
  endgenerate

  // Scan from the far end so the shortest distance is the one that sticks
  always_comb begin
    w_hit = |w_match;
    w_per = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_match[i]) w_per = PER_W'(i + 1);
    end
  end

  assign w_steps_nxt = r_steps + STEP_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_hv          <= '0;
      r_found       <= 1'b0;
      r_period      <= '0;
      r_cycle_state <= '0;
      r_steps       <= '0;
      r_timeout     <= 1'b0;
      r_busy        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_hist[i] <= '0;
    end else if (start) begin
      r_state       <= S_RUN;
      r_hist[0]     <= x;
      r_hv          <= c_hv_first;
      r_found       <= 1'b0;
      r_period      <= '0;
      r_cycle_state <= '0;
      r_steps       <= '0;
      r_timeout     <= 1'b0;
      r_busy        <= 1'b1;
    end else begin
      case (r_state)
        S_RUN: begin
          if (valid) begin
            r_steps <= w_steps_nxt;
            if (w_hit) begin
              r_state       <= S_DONE;
              r_found       <= 1'b1;
              r_period      <= w_per;
              r_cycle_state <= x;
              r_busy        <= 1'b0;
            end else begin
              for (int i = DEPTH - 1; i > 0; i--) r_hist[i] <= r_hist[i-1];
              r_hist[0] <= x;
              r_hv      <= {r_hv[DEPTH-2:0], 1'b1};
              if (w_steps_nxt == c_max_steps) begin
                r_state   <= S_TOUT;
                r_timeout <= 1'b1;
                r_busy    <= 1'b0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign found       = r_found;
  assign period      = r_period;
  assign cycle_state = r_cycle_state;
  assign steps       = r_steps;
  assign timeout     = r_timeout;
  assign busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_attractor_detect.sv
// ============================================================================
// Module   : tb_attractor_detect
// Function : Directed and randomized checks of attractor_detect against a
//            trajectory-list reference model, on two MAX_STEPS settings.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_attractor_detect;

  localparam int W      = 8;
  localparam int DEPTH  = 8;
  localparam int STEP_W = 8;
  localparam int PER_W  = 4;
  localparam int MAXA   = 20;
  localparam int MAXB   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst   = 1'b0;
  logic         start = 1'b0;
  logic         valid = 1'b0;
  logic [W-1:0] x     = '0;

  logic              found_a, timeout_a, busy_a, found_b, timeout_b, busy_b;
  logic [PER_W-1:0]  period_a, period_b;
  logic [W-1:0]      cs_a, cs_b;
  logic [STEP_W-1:0] steps_a, steps_b;

  attractor_detect #(.W(W), .DEPTH(DEPTH), .STEP_W(STEP_W), .MAX_STEPS(MAXA), .PER_W(PER_W)) dut_a (
    .clk(clk), .rst(rst), .start(start), .valid(valid), .x(x),
    .found(found_a), .period(period_a), .cycle_state(cs_a), .steps(steps_a),
    .timeout(timeout_a), .busy(busy_a));

  attractor_detect #(.W(W), .DEPTH(DEPTH), .STEP_W(STEP_W), .MAX_STEPS(MAXB), .PER_W(PER_W)) dut_b (
    .clk(clk), .rst(rst), .start(start), .valid(valid), .x(x),
    .found(found_b), .period(period_b), .cycle_state(cs_b), .steps(steps_b),
    .timeout(timeout_b), .busy(busy_b));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: full list of states since start, searched backwards
  logic [W-1:0] traj [2][256];
  int           len    [2];
  int           m_steps[2];
  int           m_found[2];
  int           m_tout [2];
  int           m_busy [2];
  int           m_per  [2];
  int           m_cs   [2];

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step(input int i, input int max_steps);
    int k;
    if (!rst) begin
      len[i] = 0; m_steps[i] = 0; m_found[i] = 0; m_tout[i] = 0;
      m_busy[i] = 0; m_per[i] = 0; m_cs[i] = 0;
    end else if (start) begin
      traj[i][0] = x; len[i] = 1; m_steps[i] = 0; m_found[i] = 0;
      m_tout[i] = 0; m_busy[i] = 1; m_per[i] = 0; m_cs[i] = 0;
    end else if (m_busy[i] != 0 && valid) begin
      m_steps[i]++;
      k = 0;
      for (int d = 1; d <= DEPTH; d++)
        if (k == 0 && d <= len[i] && traj[i][len[i]-d] == x) k = d;
      if (k != 0) begin
        m_found[i] = 1; m_per[i] = k; m_cs[i] = int'(x); m_busy[i] = 0;
      end else begin
        traj[i][len[i]] = x;
        len[i]++;
        if (m_steps[i] == max_steps) begin
          m_tout[i] = 1; m_busy[i] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("a_found",   int'(found_a),   m_found[0]);
    check("a_period",  int'(period_a),  m_per[0]);
    check("a_cstate",  int'(cs_a),      m_cs[0]);
    check("a_steps",   int'(steps_a),   m_steps[0]);
    check("a_timeout", int'(timeout_a), m_tout[0]);
    check("a_busy",    int'(busy_a),    m_busy[0]);
    check("b_found",   int'(found_b),   m_found[1]);
    check("b_period",  int'(period_b),  m_per[1]);
    check("b_cstate",  int'(cs_b),      m_cs[1]);
    check("b_steps",   int'(steps_b),   m_steps[1]);
    check("b_timeout", int'(timeout_b), m_tout[1]);
    check("b_busy",    int'(busy_b),    m_busy[1]);
  endtask

  task automatic cyc(input logic r, input logic s, input logic v, input logic [W-1:0] xv);
    rst = r; start = s; valid = v; x = xv;
    @(posedge clk);
    model_step(0, MAXA);
    model_step(1, MAXB);
    #1;
    compare_all();
  endtask

  logic [W-1:0] fmap [16];
  logic [W-1:0] cur;

  initial begin
    #1;
    cyc(1'b0, 1'b1, 1'b1, 8'hFF);
    check("rst_found", int'(found_a), 0);
    check("rst_busy",  int'(busy_a),  0);

    // Fixed point
    cyc(1'b1, 1'b1, 1'b0, 8'h5A);
    cyc(1'b1, 1'b0, 1'b1, 8'h5A);
    check("t1_found", int'(found_a), 1);
    check("t1_period", int'(period_a), 1);
    check("t1_cstate", int'(cs_a), 'h5A);
    check("t1_steps", int'(steps_a), 1);

    // Period 2
    cyc(1'b1, 1'b1, 1'b0, 8'h01);
    cyc(1'b1, 1'b0, 1'b1, 8'h02);
    cyc(1'b1, 1'b0, 1'b1, 8'h01);
    check("t2_period", int'(period_a), 2);
    check("t2_steps", int'(steps_a), 2);

    // Transient then period 3, with a gap
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 8'h10);
    cyc(1'b1, 1'b0, 1'b1, 8'h20);
    cyc(1'b1, 1'b0, 1'b1, 8'h30);
    cyc(1'b1, 1'b0, 1'b0, 8'h20);
    cyc(1'b1, 1'b0, 1'b0, 8'h20);
    cyc(1'b1, 1'b0, 1'b1, 8'h40);
    cyc(1'b1, 1'b0, 1'b1, 8'h20);
    cyc(1'b1, 1'b0, 1'b1, 8'h40);
    cyc(1'b1, 1'b0, 1'b1, 8'h40);
    check("t3_period", int'(period_a), 3);
    check("t3_steps", int'(steps_a), 5);
    check("t3_cstate", int'(cs_a), 'h20);

    // Period 9 exceeds DEPTH: timeout on sample MAXA
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 1; i <= MAXA; i++) cyc(1'b1, 1'b0, 1'b1, 8'(i % 9));
    check("t4_timeout", int'(timeout_a), 1);
    check("t4_found", int'(found_a), 0);
    check("t4_steps", int'(steps_a), MAXA);

    // Match on the MAXB-th sample wins over timeout
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 8'h01);
    cyc(1'b1, 1'b0, 1'b1, 8'h02);
    cyc(1'b1, 1'b0, 1'b1, 8'h03);
    cyc(1'b1, 1'b0, 1'b1, 8'h01);
    check("t4b_found", int'(found_b), 1);
    check("t4b_timeout", int'(timeout_b), 0);
    check("t4b_period", int'(period_b), 3);

    // Restart mid-run, then start in DONE
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 8'h01);
    cyc(1'b1, 1'b0, 1'b1, 8'h02);
    cyc(1'b1, 1'b0, 1'b1, 8'h03);
    cyc(1'b1, 1'b1, 1'b1, 8'h77);
    check("t5_steps", int'(steps_a), 0);
    check("t5_busy", int'(busy_a), 1);
    cyc(1'b1, 1'b0, 1'b1, 8'h77);
    check("t5_period", int'(period_a), 1);
    cyc(1'b1, 1'b1, 1'b0, 8'h09);
    check("t5_clr_found", int'(found_a), 0);
    check("t5_clr_cstate", int'(cs_a), 0);

    // Reset beats start/valid, mid-RUN and in DONE
    cyc(1'b1, 1'b0, 1'b1, 8'h0A);
    cyc(1'b0, 1'b1, 1'b1, 8'h0A);
    check("t6_busy", int'(busy_a), 0);
    cyc(1'b1, 1'b0, 1'b1, 8'h0A);
    check("t6_idle_steps", int'(steps_a), 0);
    cyc(1'b1, 1'b1, 1'b0, 8'h33);
    cyc(1'b1, 1'b0, 1'b1, 8'h33);
    cyc(1'b0, 1'b1, 1'b1, 8'h33);
    check("t6_found", int'(found_a), 0);
    cyc(1'b1, 1'b0, 1'b1, 8'h33);

    // Random deterministic maps over a small state space
    for (int rep = 0; rep < 40; rep++) begin
      for (int j = 0; j < 16; j++) fmap[j] = 8'($urandom_range(0, 15));
      cur = 8'($urandom_range(0, 15));
      cyc(($urandom_range(0, 30) != 0), 1'b1, 1'($urandom_range(0, 1)), cur);
      for (int c = 0; c < 60; c++) begin
        logic s, v, r;
        r = ($urandom_range(0, 80) != 0);
        s = ($urandom_range(0, 40) == 0);
        v = ($urandom_range(0, 2) != 0);
        if (s) cur = 8'($urandom_range(0, 15));
        else if (v) cur = ($urandom_range(0, 20) == 0) ? 8'($urandom) : fmap[cur[3:0]];
        cyc(r, s, v, cur);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
